// File: rtl/spi_pkg.sv
// Shared definitions for the SPI blocks: frame width, FSM state encoding, counter sizing.
package spi_pkg;

    localparam int SPI_FRAME_W = 8;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_SETUP,
        SPI_LOW,
        SPI_HIGH,
        SPI_HOLD,
        SPI_GAP
    } spi_state_t;

    // Width of a down-counter that must hold (largest phase length - 1), never narrower than 1 bit.
    function automatic int spi_cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one 8-bit MSB-first frame per accepted start, full-duplex capture.
// Latency: CS_SETUP + 15*CLK_DIV + CS_HOLD cycles from acceptance to done; CS_GAP+1 more to next accept.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SPI_FRAME_W-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [SPI_FRAME_W-1:0] rx_data,
    output logic                   sclk,
    output logic                   cs_n,
    output logic                   spi_dout,
    input  logic                   spi_din
);

    localparam int CW = spi_cnt_w(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int BW = $clog2(SPI_FRAME_W);

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SPI_FRAME_W - 1);

    spi_state_t             state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    // The MSB goes straight to spi_dout at acceptance, so only the remaining bits are kept.
    logic [SPI_FRAME_W-2:0] tx_sh;
    logic [SPI_FRAME_W-1:0] rx_sh;
    logic                   phase_end;

    assign phase_end = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SPI_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            spi_dout <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (start) begin
                        tx_sh    <= tx_data[SPI_FRAME_W-2:0];
                        rx_sh    <= '0;
                        bit_cnt  <= '0;
                        cnt      <= SETUP_LD;
                        cs_n     <= 1'b0;
                        spi_dout <= tx_data[SPI_FRAME_W-1];
                        busy     <= 1'b1;
                        state    <= SPI_SETUP;
                    end
                end

                SPI_SETUP: begin
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        rx_sh <= {rx_sh[SPI_FRAME_W-2:0], spi_din};
                        cnt   <= DIV_LD;
                        state <= SPI_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SPI_HIGH: begin
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            cnt   <= HOLD_LD;
                            state <= SPI_HOLD;
                        end else begin
                            spi_dout <= tx_sh[SPI_FRAME_W-2];
                            tx_sh    <= {tx_sh[SPI_FRAME_W-3:0], 1'b0};
                            bit_cnt  <= bit_cnt + 1'b1;
                            cnt      <= DIV_LD;
                            state    <= SPI_LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SPI_LOW: begin
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        rx_sh <= {rx_sh[SPI_FRAME_W-2:0], spi_din};
                        cnt   <= DIV_LD;
                        state <= SPI_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SPI_HOLD: begin
                    if (phase_end) begin
                        cs_n     <= 1'b1;
                        spi_dout <= 1'b0;
                        rx_data  <= rx_sh;
                        done     <= 1'b1;
                        cnt      <= GAP_LD;
                        state    <= SPI_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SPI_GAP: begin
                    if (phase_end) begin
                        busy  <= 1'b0;
                        state <= SPI_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default-parameter instance plus a fast-timing instance.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, sclk, cs_n, spi_dout, spi_din;
    logic [7:0] rx_data;

    logic       start2 = 1'b0;
    logic [7:0] tx_data2 = 8'h00;
    logic       busy2, done2, sclk2, cs_n2, dout2, din2;
    logic [7:0] rx_data2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    spi_master u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
        .cs_n(cs_n), .spi_dout(spi_dout), .spi_din(spi_din)
    );

    spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_sweep (
        .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx_data2),
        .busy(busy2), .done(done2), .rx_data(rx_data2), .sclk(sclk2),
        .cs_n(cs_n2), .spi_dout(dout2), .spi_din(din2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder models: load a byte when selected, present MSB first, advance on sclk falling.
    logic [7:0] resp_val = 8'h00, resp_sh = 8'h00;
    logic [7:0] resp2_val = 8'h00, resp2_sh = 8'h00;
    assign spi_din = resp_sh[7];
    assign din2    = resp2_sh[7];
    always @(negedge cs_n)  resp_sh  = resp_val;
    always @(negedge sclk)  if (!cs_n) resp_sh = resp_sh << 1;
    always @(negedge cs_n2) resp2_sh = resp2_val;
    always @(negedge sclk2) if (!cs_n2) resp2_sh = resp2_sh << 1;

    // Pin monitor for the main instance, sampled on the falling clk edge.
    logic       sclk_q = 1'b0, cs_n_q = 1'b1, busy_q = 1'b0;
    logic [7:0] dout_bits = 8'h00;
    int rises = 0, falls = 0, hi_run = 0, last_hi = 0, hi_bad = 0, csn_toggle = 0;
    int csn_hi_run = 0, last_csn_gap = 0, busy_lo_run = 0, last_busy_gap = 0;
    int acc_cyc = 0, done_cyc = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (sclk && !sclk_q) begin
            rises     <= rises + 1;
            dout_bits <= {dout_bits[6:0], spi_dout};
            hi_run    <= 1;
        end else if (sclk) begin
            hi_run <= hi_run + 1;
        end
        if (!sclk && sclk_q) begin
            falls   <= falls + 1;
            last_hi <= hi_run;
            if (hi_run != 4) hi_bad <= hi_bad + 1;
        end
        if (cs_n && cs_n_q && (sclk != sclk_q)) csn_toggle <= csn_toggle + 1;
        if (!cs_n && cs_n_q) last_csn_gap <= csn_hi_run;
        csn_hi_run <= cs_n ? csn_hi_run + 1 : 0;
        if (busy && !busy_q) begin
            acc_cyc       <= cyc;
            last_busy_gap <= busy_lo_run;
        end
        busy_lo_run <= busy ? 0 : busy_lo_run + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        sclk_q <= sclk;
        cs_n_q <= cs_n;
        busy_q <= busy;
    end

    // Lighter monitor for the fast-timing instance.
    logic       sclk2_q = 1'b0, busy2_q = 1'b0;
    logic [7:0] dout2_bits = 8'h00;
    int rises2 = 0, acc2_cyc = 0, done2_cyc = 0;

    always @(negedge clk) begin
        if (sclk2 && !sclk2_q) begin
            rises2     <= rises2 + 1;
            dout2_bits <= {dout2_bits[6:0], dout2};
        end
        if (busy2 && !busy2_q) acc2_cyc <= cyc;
        if (done2) done2_cyc <= cyc;
        sclk2_q <= sclk2;
        busy2_q <= busy2;
    end

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        start   = 1'b1;
        tx_data = d;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        int r0;
        repeat (3) @(negedge clk);
        total++; if (cs_n !== 1'b1)    begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
        total++; if (sclk !== 1'b0)    begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        total++; if (spi_dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", spi_dout); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", rx_data); end
        rst_n = 1'b1;
        r0 = rises;
        repeat (20) @(negedge clk);
        #1;
        total++; if (rises != r0)      begin bad++; $display("FAIL idle_sclk rises=%0d want=0", rises - r0); end
        total++; if (cs_n !== 1'b1)    begin bad++; $display("FAIL idle_cs_n got=%b want=1", cs_n); end
    endtask

    task automatic test_single_frame;
        int r0, f0, d0;
        logic seen;
        resp_val = 8'h3C;
        r0 = rises; f0 = falls; d0 = done_cnt;
        pulse_start(8'hA5);
        wait_done(seen);
        total++; if (!seen) begin bad++; $display("FAIL single_done timeout got=0 want=1"); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL single_rx got=%h want=3c", rx_data); end
        total++; if (done_cyc - acc_cyc != 68) begin bad++; $display("FAIL single_len got=%0d want=68", done_cyc - acc_cyc); end
        total++; if (dout_bits !== 8'hA5) begin bad++; $display("FAIL single_dout got=%h want=a5", dout_bits); end
        total++; if (rises - r0 != 8) begin bad++; $display("FAIL single_rises got=%0d want=8", rises - r0); end
        total++; if (falls - f0 != 8) begin bad++; $display("FAIL single_falls got=%0d want=8", falls - f0); end
        total++; if (hi_bad != 0 || last_hi != 4) begin bad++; $display("FAIL single_high_width got=%0d bad=%0d want=4", last_hi, hi_bad); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap got=%b want=1", busy); end
        @(negedge clk); #1;
        total++; if (done !== 1'b0 || done_cnt - d0 != 1) begin bad++; $display("FAIL single_done_pulse got=%b cnt=%0d want=0 cnt=1", done, done_cnt - d0); end
        repeat (6) @(negedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
        total++; if (csn_toggle != 0) begin bad++; $display("FAIL single_sclk_while_deselected got=%0d want=0", csn_toggle); end
    endtask

    task automatic test_back_to_back;
        int d0, acc_first;
        logic seen;
        resp_val = 8'h96;
        d0 = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        tx_data = 8'hFF;
        wait_done(seen);
        acc_first = acc_cyc;
        total++; if (!seen) begin bad++; $display("FAIL b2b_first timeout got=0 want=1"); end
        total++; if (dout_bits !== 8'hFF) begin bad++; $display("FAIL b2b_first_dout got=%h want=ff", dout_bits); end
        tx_data = 8'h00;
        wait_done(seen);
        start = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL b2b_second timeout got=0 want=1"); end
        total++; if (dout_bits !== 8'h00) begin bad++; $display("FAIL b2b_second_dout got=%h want=00", dout_bits); end
        total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL b2b_rx got=%h want=96", rx_data); end
        total++; if (acc_cyc - acc_first != 73) begin bad++; $display("FAIL b2b_period got=%0d want=73", acc_cyc - acc_first); end
        total++; if (last_csn_gap != 5) begin bad++; $display("FAIL b2b_cs_gap got=%0d want=5", last_csn_gap); end
        total++; if (last_busy_gap != 1) begin bad++; $display("FAIL b2b_busy_gap got=%0d want=1", last_busy_gap); end
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", done_cnt - d0); end
        total++; if (hi_bad != 0) begin bad++; $display("FAIL b2b_high_width bad=%0d want=0", hi_bad); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ignored_request;
        int r0, d0;
        logic seen;
        resp_val = 8'h81;
        r0 = rises; d0 = done_cnt;
        pulse_start(8'hC3);
        for (int i = 0; i < 300 && rises - r0 < 4; i++) begin
            @(negedge clk); #1;
        end
        total++; if (rises - r0 != 4) begin bad++; $display("FAIL ignored_reach_bit3 rises=%0d want=4", rises - r0); end
        pulse_start(8'h12);
        wait_done(seen);
        total++; if (!seen) begin bad++; $display("FAIL ignored_done timeout got=0 want=1"); end
        total++; if (dout_bits !== 8'hC3) begin bad++; $display("FAIL ignored_dout got=%h want=c3", dout_bits); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL ignored_rx got=%h want=81", rx_data); end
        repeat (100) @(negedge clk); #1;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignored_frames got=%0d want=1", done_cnt - d0); end
        total++; if (rises - r0 != 8) begin bad++; $display("FAIL ignored_rises got=%0d want=8", rises - r0); end
        total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin bad++; $display("FAIL ignored_idle busy=%b cs_n=%b want=0/1", busy, cs_n); end
    endtask

    task automatic test_reset_mid_frame;
        int r0, d0;
        resp_val = 8'hFF;
        r0 = rises; d0 = done_cnt;
        pulse_start(8'h77);
        for (int i = 0; i < 300 && !(rises - r0 == 5 && sclk); i++) begin
            @(negedge clk); #1;
        end
        total++; if (!(rises - r0 == 5 && sclk)) begin bad++; $display("FAIL midrst_reach_bit4 rises=%0d sclk=%b want=5/1", rises - r0, sclk); end
        rst_n = 1'b0;
        #1;
        total++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin bad++; $display("FAIL midrst_pins cs_n=%b sclk=%b want=1/0", cs_n, sclk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk); #1;
        total++; if (done_cnt != d0) begin bad++; $display("FAIL midrst_done got=%0d want=0", done_cnt - d0); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx got=%h want=00", rx_data); end
        total++; if (rises - r0 != 5) begin bad++; $display("FAIL midrst_rises got=%0d want=5", rises - r0); end
    endtask

    task automatic test_sweep;
        int r0;
        logic seen;
        resp2_val = 8'h5A;
        r0 = rises2;
        @(negedge clk);
        start2   = 1'b1;
        tx_data2 = 8'h5A;
        @(negedge clk);
        start2   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done2) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        total++; if (!seen) begin bad++; $display("FAIL sweep_done timeout got=0 want=1"); end
        total++; if (done2_cyc - acc2_cyc != 32) begin bad++; $display("FAIL sweep_len got=%0d want=32", done2_cyc - acc2_cyc); end
        total++; if (rx_data2 !== 8'h5A) begin bad++; $display("FAIL sweep_rx got=%h want=5a", rx_data2); end
        total++; if (dout2_bits !== 8'h5A) begin bad++; $display("FAIL sweep_dout got=%h want=5a", dout2_bits); end
        total++; if (rises2 - r0 != 8) begin bad++; $display("FAIL sweep_rises got=%0d want=8", rises2 - r0); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_ignored_request;
        test_reset_mid_frame;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
